// File: rtl/muldiv_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter_if
// Description : Start/done handshake bundle between EX and the iterative
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start_i;
    logic [1:0]             op_i;
    logic [WIDTH-1:0]       a_i;
    logic [WIDTH-1:0]       b_i;
    logic                   annul_i;
    logic                   busy_o;
    logic                   done_o;
    logic [2*WIDTH-1:0]     result_o;
    logic                   div_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, annul_i,
        input  busy_o, done_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, annul_i,
        output busy_o, done_o, result_o, div_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : WIDTH-generic iterative multiply/divide, one bit per cycle
//               (shift-add multiply, restoring divide) with sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input wire            clk,
    input wire            rst,
    muldiv_iter_if.slave  bus
);
    localparam int               c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_launch;
    logic                   w_commit;

    logic                   r_is_div;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic                   r_div_zero;
    logic [c_CW-1:0]        r_cnt;
    logic [WIDTH-1:0]       r_opnd;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_done;
    logic                   r_dz_out;
    logic [2*WIDTH-1:0]     r_result;

    // Operand capture: signed ops are mult (00) and div (10)
    logic                   w_signed;
    logic                   w_sa;
    logic                   w_sb;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_start_dz;

    assign w_signed   = ~bus.op_i[0];
    assign w_sa       = w_signed & bus.a_i[WIDTH-1];
    assign w_sb       = w_signed & bus.b_i[WIDTH-1];
    assign w_a_mag    = w_sa ? -bus.a_i : bus.a_i;
    assign w_b_mag    = w_sb ? -bus.b_i : bus.b_i;
    assign w_start_dz = bus.op_i[1] & (bus.b_i == '0);

    // One iteration of each algorithm
    logic [WIDTH:0]         w_hi_sum;
    logic [2*WIDTH-1:0]     w_mul_nxt;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH:0]         w_diff;
    logic [2*WIDTH-1:0]     w_div_nxt;

    assign w_hi_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_hi_sum, r_acc[WIDTH-1:1]};
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_div_nxt = w_diff[WIDTH]
                     ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Sign correction wraps modulo the field width, so -2^(W-1)/-1 is harmless
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;
    logic [2*WIDTH-1:0]     w_final;

    assign w_prod  = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quot  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem   = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_final = r_div_zero ? '0 : (r_is_div ? {w_rem, w_quot} : w_prod);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = w_start_dz ? S_SIGN : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.annul_i)           w_state_nxt = S_IDLE;
                else if (r_cnt == c_LAST)  w_state_nxt = S_SIGN;
            end
            S_SIGN: begin
                w_state_nxt = S_IDLE;
                w_commit    = ~bus.annul_i;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_dz_out   <= 1'b0;
            r_result   <= '0;
        end else begin
            r_done <= w_commit;
            if (w_launch) begin
                r_is_div   <= bus.op_i[1];
                r_sign_a   <= w_sa;
                r_sign_b   <= w_sb;
                r_div_zero <= w_start_dz;
                r_cnt      <= '0;
                if (bus.op_i[1]) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                    r_opnd <= w_b_mag;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                    r_opnd <= w_a_mag;
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + c_CW'(1);
                r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
            end
            if (w_commit) begin
                r_result <= w_final;
                r_dz_out <= r_div_zero;
            end
        end
    end

    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.done_o     = r_done;
    assign bus.result_o   = r_result;
    assign bus.div_zero_o = r_dz_out;
endmodule
`default_nettype wire
